// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//
// Sequencing controller for the single instruction-memory port. A start command
// clears every memory word. It then loads a program that arrives as a
// little-endian byte stream with a valid/ready handshake. The core is held in
// stall for the whole load. Outside a load, the core PC drives the memory
// address.
//
// Ports
//   SYS_clk      system clock, rising edge
//   SYS_reset    asynchronous active-low reset
//   start        begin a load (sampled only in idle)
//   len_words    words to load, latched with start, clamped to DEPTH
//   byte_valid   load byte present
//   byte_data    load byte
//   byte_ready   byte accepted this cycle when byte_valid is also high
//   PC           core fetch word index
//   mem_addr     memory word address
//   mem_wdata    memory write data
//   mem_we       memory write enable, one word per cycle
//   cpu_stall    core must hold PC and not retire
//   busy         load in progress
//   done         one-cycle pulse at load completion
//   err          sticky: len_words was clamped; cleared by the next accepted start
//   fetch_fault  PC >= DEPTH while idle

module imem_load_ctrl #(
    parameter int unsigned DEPTH  = 1000,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       PC,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fetch_fault
);

    localparam logic [ADDR_W:0] CntOne   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DepthW   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LastAddr = DepthW - CntOne;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            err_q      <= 1'b0;
            clr_cnt_q  <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            err_q      <= err_d;
            clr_cnt_q  <= clr_cnt_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        err_d       = err_q;
        clr_cnt_d   = clr_cnt_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        byte_ready  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        cpu_stall   = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;
        fetch_fault = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpu_stall   = 1'b0;
                busy        = 1'b0;
                fetch_fault = (PC >= DEPTH);
                // An out-of-range PC must not alias onto a valid word.
                mem_addr    = fetch_fault ? '0 : PC[ADDR_W-1:0];
                if (start) begin
                    if (len_words > DepthW) begin
                        len_d = DepthW;
                        err_d = 1'b1;
                    end else begin
                        len_d = len_words;
                        err_d = 1'b0;
                    end
                    clr_cnt_d  = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    state_d    = StClear;
                end
            end
            StClear: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q[ADDR_W-1:0];
                clr_cnt_d = clr_cnt_q + CntOne;
                if (clr_cnt_q == LastAddr) begin
                    state_d = (len_q == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    // Two-bit counter wraps back to 0 after the fourth byte.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                mem_we     = 1'b1;
                mem_addr   = word_cnt_q[ADDR_W-1:0];
                mem_wdata  = asm_q;
                word_cnt_d = word_cnt_q + CntOne;
                state_d    = (word_cnt_d == len_q) ? StDone : StLoad;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: directed loads with hand-computed expectations.
// Write traffic is logged at the falling edge and compared after each load.
// The bench counts cycles from the start edge: the first CLEAR cycle is cycle 1.

module tb_imem_load_ctrl;

    localparam int unsigned DEPTH  = 1000;
    localparam int unsigned ADDR_W = 10;

    logic              SYS_clk;
    logic              SYS_reset;
    logic              start;
    logic [ADDR_W:0]   len_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [31:0]       PC;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_stall;
    logic              busy;
    logic              done;
    logic              err;
    logic              fetch_fault;

    imem_load_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .start       (start),
        .len_words   (len_words),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .PC          (PC),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .cpu_stall   (cpu_stall),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .fetch_fault (fetch_fault)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_rel = 0;
    int stall_bad = 0;
    bit in_load  = 1'b0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [7:0]        prog[$];

    always @(posedge SYS_clk) cycle <= cycle + 1;

    always @(negedge SYS_clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (in_load && !(cpu_stall && busy)) stall_bad++;
        if (done) begin
            done_cnt++;
            done_rel = cycle - start_cyc + 1;
            in_load  = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
    endfunction

    task automatic set_prog_two_words();
        prog.delete();
        prog.push_back(8'h13); prog.push_back(8'h00); prog.push_back(8'h00); prog.push_back(8'h00);
        prog.push_back(8'h93); prog.push_back(8'h00); prog.push_back(8'h10); prog.push_back(8'h00);
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        wr_addr.delete();
        wr_data.delete();
        done_cnt  = 0;
        done_rel  = 0;
        stall_bad = 0;
        @(posedge SYS_clk); #1;
        start     = 1'b1;
        len_words = len;
        @(posedge SYS_clk); #1;
        start     = 1'b0;
        start_cyc = cycle;
        in_load   = 1'b1;
    endtask

    // Drives prog[first..last_excl-1]. With gap > 0, each byte is preceded by
    // gap cycles in which the controller is ready but byte_valid is low.
    task automatic drive_bytes(input string tag, input int first, input int last_excl,
                               input int gap);
        int idx   = first;
        int guard = 0;
        int idle;
        bit acc;
        while (idx < last_excl && guard < 20000) begin
            byte_valid = 1'b0;
            idle = 0;
            while (idle < gap && guard < 20000) begin
                @(negedge SYS_clk);
                if (byte_ready) idle++;
                guard++;
                @(posedge SYS_clk); #1;
            end
            byte_valid = 1'b1;
            byte_data  = prog[idx];
            acc = 1'b0;
            while (!acc && guard < 20000) begin
                @(negedge SYS_clk);
                acc = byte_ready;
                guard++;
                @(posedge SYS_clk); #1;
            end
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        check_eq({tag, "_bytes_sent"}, idx, last_excl);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int g = 0;
        while (done_cnt == 0 && g < budget) begin
            @(negedge SYS_clk); #1;
            g++;
        end
        @(posedge SYS_clk); #1;
        check_eq({tag, "_idle_busy"}, busy, 1'b0);
        check_eq({tag, "_idle_stall"}, cpu_stall, 1'b0);
    endtask

    task automatic check_load(input string tag, input int nwords, input int exp_done);
        int bad = 0;
        check_eq({tag, "_nwrites"}, wr_addr.size(), DEPTH + nwords);
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= wr_addr.size()) bad++;
            else if (wr_addr[i] != i[ADDR_W-1:0] || wr_data[i] != 32'h0) bad++;
        end
        check_eq({tag, "_clear_bad"}, bad, 0);
        bad = 0;
        for (int k = 0; k < nwords; k++) begin
            if (DEPTH + k >= wr_addr.size()) bad++;
            else if (wr_addr[DEPTH+k] != k[ADDR_W-1:0] || wr_data[DEPTH+k] != exp_word(k)) bad++;
        end
        check_eq({tag, "_words_bad"}, bad, 0);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_done_cycle"}, done_rel, exp_done);
        check_eq({tag, "_stall_gaps"}, stall_bad, 0);
    endtask

    initial begin
        int cnt3;
        SYS_reset  = 1'b0;
        start      = 1'b0;
        len_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        PC         = 32'd5;

        // Reset and idle behaviour
        #12;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_we", mem_we, 1'b0);
        @(posedge SYS_clk); #1;
        SYS_reset = 1'b1;
        @(negedge SYS_clk);
        check_eq("idle_addr_pc5", mem_addr, 32'd5);
        check_eq("idle_we", mem_we, 1'b0);
        check_eq("idle_stall", cpu_stall, 1'b0);
        check_eq("idle_ready", byte_ready, 1'b0);
        check_eq("idle_fault_pc5", fetch_fault, 1'b0);
        PC = 32'd1000; #1;
        check_eq("fault_pc1000", fetch_fault, 1'b1);
        check_eq("addr_pc1000", mem_addr, 32'd0);
        PC = 32'd999; #1;
        check_eq("fault_pc999", fetch_fault, 1'b0);
        check_eq("addr_pc999", mem_addr, 32'd999);
        PC = 32'd5;

        // Two-word load, back-to-back bytes: 4+1 cycles per word after 1000 CLEAR
        set_prog_two_words();
        do_start(11'd2);
        check_eq("t1_busy", busy, 1'b1);
        drive_bytes("t1", 0, 8, 0);
        wait_done("t1", 200);
        check_load("t1", 2, 1011);
        check_eq("t1_word0", (wr_data.size() > 1000) ? wr_data[1000] : 32'hx, 32'h0000_0013);
        check_eq("t1_word1", (wr_data.size() > 1001) ? wr_data[1001] : 32'hx, 32'h0010_0093);

        // Backpressure: 3 idle LOAD cycles ahead of each of the 8 bytes -> +24
        do_start(11'd2);
        drive_bytes("t2", 0, 8, 3);
        wait_done("t2", 200);
        check_load("t2", 2, 1035);

        // Zero length: CLEAR only; PC out of range is not a fault while busy
        PC = 32'd1000;
        do_start(11'd0);
        check_eq("t3_err", err, 1'b0);
        check_eq("t3_fault_busy", fetch_fault, 1'b0);
        check_eq("t3_clr_addr0", mem_addr, 32'd0);
        wait_done("t3", 1200);
        check_load("t3", 0, 1001);
        PC = 32'd5;

        // Oversized length clamps to DEPTH and sets sticky err
        prog.delete();
        for (int i = 0; i < 4 * DEPTH; i++) prog.push_back(8'((i * 7 + 3) & 255));
        do_start(11'd1500);
        check_eq("t4_err_set", err, 1'b1);
        drive_bytes("t4", 0, 4 * DEPTH, 0);
        wait_done("t4", 200);
        check_load("t4", DEPTH, DEPTH + 5 * DEPTH + 1);
        check_eq("t4_err_sticky", err, 1'b1);

        // Next accepted start clears err
        do_start(11'd0);
        check_eq("t5_err_clr", err, 1'b0);
        wait_done("t5", 1200);
        check_eq("t5_done_cycle", done_rel, 1001);

        // Asynchronous reset mid-cycle during CLEAR with err set
        do_start(11'd1600);
        check_eq("t6_err_set", err, 1'b1);
        repeat (3) @(posedge SYS_clk);
        #3;
        SYS_reset = 1'b0;
        #1;
        in_load = 1'b0;
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_stall", cpu_stall, 1'b0);
        check_eq("t6_ready", byte_ready, 1'b0);
        check_eq("t6_we", mem_we, 1'b0);
        check_eq("t6_wdata", mem_wdata, 32'h0);
        check_eq("t6_done", done, 1'b0);
        check_eq("t6_err", err, 1'b0);
        @(posedge SYS_clk); #1;
        SYS_reset = 1'b1;
        @(negedge SYS_clk);
        check_eq("t6_idle_addr", mem_addr, 32'd5);

        // Reset during LOAD after 2 bytes of word 3: no write to address 3
        set_prog_two_words();
        for (int i = 0; i < 12; i++) prog.push_back(8'(8'hA0 + i));
        do_start(11'd5);
        drive_bytes("t7", 0, 14, 0);
        #2;
        SYS_reset = 1'b0;
        #1;
        in_load = 1'b0;
        check_eq("t7_busy", busy, 1'b0);
        check_eq("t7_ready", byte_ready, 1'b0);
        check_eq("t7_nwrites", wr_addr.size(), DEPTH + 3);
        cnt3 = 0;
        for (int i = DEPTH; i < wr_addr.size(); i++) if (wr_addr[i] == 10'd3) cnt3++;
        check_eq("t7_addr3_writes", cnt3, 0);
        @(posedge SYS_clk); #1;
        SYS_reset = 1'b1;

        // Fresh load after reset behaves as from reset
        set_prog_two_words();
        do_start(11'd2);
        drive_bytes("t8", 0, 8, 0);
        wait_done("t8", 200);
        check_load("t8", 2, 1011);

        // start pulsed during LOAD with another length is ignored
        do_start(11'd2);
        drive_bytes("t9a", 0, 2, 0);
        start     = 1'b1;
        len_words = 11'd7;
        @(posedge SYS_clk); #1;
        start     = 1'b0;
        drive_bytes("t9b", 2, 8, 0);
        wait_done("t9", 200);
        check_load("t9", 2, 1012);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencing controller for the instruction memory. On a start command it clears every memory word, then writes a program into the instruction memory. The program arrives as a byte stream with a valid/ready handshake. The controller holds the core in stall for the whole load. Outside a load it passes the core's PC through to the memory address port. It sits between the core fetch stage, the program-load source (UART/debug bridge) and the single instruction-memory port.

## Interface
- DEPTH, 1000, number of 32-bit instruction words in memory
- ADDR_W, 10, memory word-address width (2^ADDR_W >= DEPTH)
- SYS_clk  in  1  system clock, rising edge
- SYS_reset  in  1  asynchronous, active-low reset
- start  in  1  begin load, sampled only in IDLE
- len_words  in  ADDR_W+1  number of words to load, latched with start
- byte_valid  in  1  load byte present
- byte_data  in  8  load byte
- byte_ready  out  1  controller accepts byte this cycle
- PC  in  32  core fetch word index
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable, one word per cycle
- cpu_stall  out  1  core must hold PC and not retire
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- err  out  1  sticky: len_words clamped; cleared by next accepted start
- fetch_fault  out  1  PC >= DEPTH while IDLE

## Operation
- States: IDLE, CLEAR, LOAD, WRITE, DONE.
- IDLE:
  - mem_addr = PC[ADDR_W-1:0], mem_we=0, cpu_stall=0, busy=0.
  - fetch_fault = (PC >= DEPTH); when set, mem_addr=0.
  - start=1 latches len = min(len_words, DEPTH), sets err = (len_words > DEPTH), clears clr_cnt/word_cnt/byte_cnt, then goes to CLEAR.
- CLEAR:
  - mem_we=1, mem_addr=clr_cnt, mem_wdata=0.
  - clr_cnt increments each cycle.
  - After writing address DEPTH-1: go to DONE if len==0, else LOAD.
- LOAD:
  - byte_ready=1. A byte is taken on byte_valid && byte_ready.
  - Bytes are assembled little-endian: the first byte is bits [7:0], the fourth is [31:24].
  - After the 4th accepted byte, byte_cnt returns to 0 and the state goes to WRITE.
  - Gaps in byte_valid are legal and just wait.
- WRITE:
  - byte_ready=0, mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word.
  - word_cnt increments.
  - Go to DONE if the new word_cnt == len, else LOAD.
- DONE: done=1 for one cycle, then IDLE.
- cpu_stall=1 and busy=1 in CLEAR, LOAD, WRITE and DONE.
- start outside IDLE is ignored; len_words is not re-sampled.
- Bytes offered outside LOAD are not accepted (byte_ready=0). Extra bytes after the last word stay unaccepted.
- Counter widths: clr_cnt and word_cnt are ADDR_W+1 bits. The clamp guarantees they never exceed DEPTH, so there is no wrap.

## Timing
- State, counters, assembly register and err are registered. Outputs decode combinationally from state and registers; PC passes through combinationally in IDLE.
- Reset (SYS_reset=0) takes effect immediately, asynchronously, in any state:
  - State goes to IDLE; all counters and the assembly register go to 0.
  - byte_ready=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0, cpu_stall=0.
  - A partially assembled word is discarded. Memory content after reset mid-load is undefined and is not repaired.
- Load latency:
  - Cycle 0: start sampled.
  - Cycles 1..DEPTH: CLEAR.
  - Then, per word: at least 4 LOAD cycles plus 1 WRITE cycle.
  - Then 1 DONE cycle.
  - Minimum total for N words: DEPTH + 5N + 1 cycles after the start edge.
- Earliest next start is sampled in the first IDLE cycle after DONE.
- If byte_valid is high in the WRITE cycle, the byte is held by the source and accepted in the next LOAD cycle.

## Test plan
- Reset/idle:
  - Assert reset mid-cycle -> all outputs at reset values immediately.
  - Release with PC=5 -> mem_addr=5, mem_we=0, cpu_stall=0.
  - PC=1000 -> fetch_fault=1, mem_addr=0.
- Two-word load, back-to-back bytes:
  - Stimulus: len_words=2, bytes 13 00 00 00 93 00 10 00.
  - Required: 1000 zero writes at addresses 0..999, then 0x00000013 at address 0 and 0x00100093 at address 1.
  - done pulses exactly at cycle 1011 after start; cpu_stall high throughout, then low.
- Backpressure: same program with byte_valid low for 3 cycles between every byte -> identical memory writes; done delayed by 24 cycles.
- Edge lengths:
  - len_words=0 -> CLEAR only, done at cycle 1001, err=0.
  - len_words=1500 -> err=1, exactly 1000 words written, then done.
  - The next accepted start clears err.
- Reset during LOAD after 2 bytes of word 3 -> IDLE immediately, no write to address 3.
  - A new load afterwards behaves as from reset.
- start pulsed during LOAD with a different len_words -> ignored; the original length completes.
